// File: rtl/fakeram_arbiter_2p_pkg.sv
// Shared types and defaults for the two-port fakeram arbiter.
// Optional statistics counters are enabled with FAKERAM_ARB_STATS_EN.
package fakeram_arb_pkg;

  localparam int BITS_DEF       = 20;
  localparam int WORD_DEPTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 6;

  typedef logic port_idx_t;

  typedef struct packed {
    logic                      we;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [BITS_DEF-1:0]       wdata;
  } ram_req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fakeram_arbiter_2p_if.sv
// Request and read-response channels for both requesters of the fakeram arbiter.
interface fakeram_arbiter_2p_if
  import fakeram_arb_pkg::*;
#(
  parameter int BITS       = BITS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_we;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*BITS-1:0]       req_wdata;
  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_ready;
  logic [2*BITS-1:0]       rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/fakeram_arbiter_2p_rr2.sv
// Two-way round-robin grant: the pointer names the port that wins a tie and
// moves to the other port after every grant.
module fakeram_arb_rr2
  import fakeram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible_i,
  output logic [1:0] grant_o
);

  port_idx_t ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    case (eligible_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|grant_o) ptr_d = ~grant_o[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fakeram_arbiter_2p.sv
// Arbiter and read sequencer for one single-port 64x20 fakeram shared by two clients.
// Define FAKERAM_ARB_STATS_EN to add per-port grant and conflict counters.
module fakeram_arbiter_2p
  import fakeram_arb_pkg::*;
#(
  parameter int BITS       = BITS_DEF,
  parameter int WORD_DEPTH = WORD_DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(WORD_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  fakeram_arbiter_2p_if.slave   bus,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [BITS-1:0]       ram_wd_o,
  input  logic [BITS-1:0]       ram_rd_i
`ifdef FAKERAM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_grants,
  output logic [15:0]           stat_conflicts
`endif
);

  ram_req_t req_p0, req_p1, gnt_req;
  logic [1:0] eligible, grant, inflight_rd;
  logic       any_grant, rd_accept;

  // Capture stage: a read accepted this cycle has its macro data valid next cycle
  logic      cap_vld_q, cap_vld_d;
  port_idx_t cap_port_q, cap_port_d;

  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [2*BITS-1:0] rsp_data_q, rsp_data_d;

  assign req_p0 = '{we: bus.req_we[0], addr: bus.req_addr[0 +: ADDR_WIDTH],
                    wdata: bus.req_wdata[0 +: BITS]};
  assign req_p1 = '{we: bus.req_we[1], addr: bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH],
                    wdata: bus.req_wdata[BITS +: BITS]};

  assign inflight_rd = {cap_vld_q & cap_port_q, cap_vld_q & ~cap_port_q};

  always_comb begin
    eligible = 2'b00;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = !rst && bus.req_valid[i] &&
                    (bus.req_we[i] ||
                     (!inflight_rd[i] && (!rsp_valid_q[i] || bus.rsp_ready[i])));
    end
  end

  fakeram_arb_rr2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .eligible_i (eligible),
    .grant_o    (grant)
  );

  assign any_grant     = |grant;
  assign gnt_req       = grant[1] ? req_p1 : req_p0;
  assign rd_accept     = any_grant & ~gnt_req.we;
  assign bus.req_ready = grant;

  // Idle cycles drive zeros so no X ever reaches the macro pins
  always_comb begin
    ram_ce_o   = any_grant;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_wd_o   = '0;
    if (any_grant) begin
      ram_we_o   = gnt_req.we;
      ram_addr_o = gnt_req.addr;
      ram_wd_o   = gnt_req.wdata;
    end
  end

  always_comb begin
    cap_vld_d  = rd_accept;
    cap_port_d = rd_accept ? grant[1] : cap_port_q;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q & ~bus.rsp_ready;
    rsp_data_d  = rsp_data_q;
    if (cap_vld_q) begin
      if (cap_port_q) begin
        rsp_valid_d[1]            = 1'b1;
        rsp_data_d[BITS +: BITS]  = ram_rd_i;
      end else begin
        rsp_valid_d[0]            = 1'b1;
        rsp_data_d[0 +: BITS]     = ram_rd_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_vld_q   <= 1'b0;
      cap_port_q  <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      cap_vld_q   <= cap_vld_d;
      cap_port_q  <= cap_port_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef FAKERAM_ARB_STATS_EN
  logic [15:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d, conf_q, conf_d;

  always_comb begin
    gcnt0_d = grant[0]    ? sat_inc16(gcnt0_q) : gcnt0_q;
    gcnt1_d = grant[1]    ? sat_inc16(gcnt1_q) : gcnt1_q;
    conf_d  = (&eligible) ? sat_inc16(conf_q)  : conf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      conf_q  <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      conf_q  <= conf_d;
    end
  end

  assign stat_grants    = {gcnt1_q, gcnt0_q};
  assign stat_conflicts = conf_q;
`endif

endmodule
